// File: rtl/ioctl_word_loader.sv
// ioctl_word_loader: packs the hps_io ioctl byte stream into OUT_W-bit little-endian
// words. The words go through a first-word-fall-through FIFO and are streamed to the
// target memory selected by ioctl_index.
//
// Handshake: a word is offered on tgt_wr (one-hot, bit = channel) with tgt_addr and
// tgt_din. It transfers on every rising clk_sys edge where |tgt_wr && tgt_req. Until
// then the offered word and its address stay unchanged. On the ioctl side, a byte is
// taken on each cycle with ioctl_wr high; hps_io only strobes while ioctl_wait is low.
module ioctl_word_loader #(
    parameter int OUT_W      = 16,
    parameter int ADDR_W     = 13,
    parameter int BUF_DEPTH  = 64,
    parameter int NUM_CH     = 2,
    parameter int INDEX_BASE = 0
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic              ioctl_wait,
    output logic [NUM_CH-1:0] tgt_wr,
    output logic [ADDR_W-1:0] tgt_addr,
    output logic [OUT_W-1:0]  tgt_din,
    input  logic              tgt_req,
    output logic [NUM_CH-1:0] loaded,
    output logic              busy,
    output logic              err
);
    localparam int BYTES  = OUT_W / 8;
    localparam int LANE_W = $clog2(BYTES);
    localparam int PTR_W  = $clog2(BUF_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                dl_q;
    logic                pending_q, pending_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [OUT_W-1:0]    word_q, word_d, merged;
    logic [LANE_W:0]     byte_cnt_q, byte_cnt_d;
    logic                push, start, done;
    logic [OUT_W-1:0]    push_data;

    logic [OUT_W-1:0]    mem [BUF_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    mem_cnt, total;
    logic                out_valid_q;
    logic                pop, full, push_ok, drop, load_out, from_mem, bypass, mem_wr;

    logic                dl_rise, dl_fall, idx_ok;
    logic [8:0]          idx_off;
    logic [LANE_W-1:0]   lane;
    logic                unused_bits;

    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl_download & dl_q;
    // Out-of-range indices below the base wrap to >= 256 and fail the compare.
    assign idx_off = {1'b0, ioctl_index} - 9'(INDEX_BASE);
    assign idx_ok  = (idx_off < 9'(NUM_CH));
    assign lane    = ioctl_addr[LANE_W-1:0];
    assign unused_bits = &{1'b0, ioctl_addr[24:LANE_W], idx_off[8:CH_W]};

    // The output register counts as one FIFO slot; it is empty only when memory is too.
    assign total    = mem_cnt + CNT_W'(out_valid_q);
    assign pop      = out_valid_q & tgt_req;
    assign full     = (total == CNT_W'(BUF_DEPTH));
    assign push_ok  = push & (~full | pop);
    assign drop     = push & ~push_ok;
    assign load_out = ~out_valid_q | pop;
    assign from_mem = load_out & (mem_cnt != '0);
    assign bypass   = load_out & (mem_cnt == '0) & push_ok;
    assign mem_wr   = push_ok & ~bypass;

    assign ioctl_wait = (total >= CNT_W'(BUF_DEPTH - 1)) || (state_q == ST_DRAIN);
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_DRAIN);

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state, byte assembly and word push decisions.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        ch_d       = ch_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        push       = 1'b0;
        push_data  = word_q;
        start      = 1'b0;
        done       = 1'b0;
        merged     = word_q;
        merged[{lane, 3'b000} +: 8] = ioctl_dout;
        case (state_q)
            ST_IDLE: begin
                if (dl_rise || pending_q) begin
                    pending_d = 1'b0;
                    if (idx_ok) begin
                        state_d    = ST_LOAD;
                        ch_d       = idx_off[CH_W-1:0];
                        start      = 1'b1;
                        word_d     = '0;
                        byte_cnt_d = '0;
                    end
                end
            end
            ST_LOAD: begin
                if (dl_fall) begin
                    // Flush a partial word; unfilled high lanes are already zero.
                    state_d    = ST_DRAIN;
                    push       = (byte_cnt_q != '0);
                    push_data  = word_q;
                    word_d     = '0;
                    byte_cnt_d = '0;
                end else if (ioctl_wr) begin
                    push_data = merged;
                    if (&lane) begin
                        push       = 1'b1;
                        word_d     = '0;
                        byte_cnt_d = '0;
                    end else begin
                        word_d     = merged;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (dl_rise) pending_d = 1'b1;
                if (total == '0) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers: download edge detect, pending restart, channel, partial word.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_q       <= 1'b0;
            pending_q  <= 1'b0;
            ch_q       <= '0;
            word_q     <= '0;
            byte_cnt_q <= '0;
        end else begin
            dl_q       <= ioctl_download;
            pending_q  <= pending_d;
            ch_q       <= ch_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // FIFO storage array (no reset; validity is tracked by the pointers).
    always_ff @(posedge clk_sys) begin
        if (mem_wr) mem[wr_ptr] <= push_data;
    end

    // FIFO pointers and the registered head word.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_cnt     <= '0;
            out_valid_q <= 1'b0;
            tgt_din     <= '0;
        end else begin
            if (mem_wr)   wr_ptr <= wr_ptr + 1'b1;
            if (from_mem) rd_ptr <= rd_ptr + 1'b1;
            mem_cnt <= mem_cnt + CNT_W'(mem_wr) - CNT_W'(from_mem);
            if (from_mem) begin
                tgt_din     <= mem[rd_ptr];
                out_valid_q <= 1'b1;
            end else if (bypass) begin
                tgt_din     <= push_data;
                out_valid_q <= 1'b1;
            end else if (load_out) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Target word address, sticky error and per-channel loaded flags.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tgt_addr <= '0;
            err      <= 1'b0;
            loaded   <= '0;
        end else if (start) begin
            tgt_addr     <= '0;
            err          <= 1'b0;
            loaded[ch_d] <= 1'b0;
        end else begin
            if (pop)                         tgt_addr <= tgt_addr + 1'b1;
            if (drop || (pop && &tgt_addr))  err      <= 1'b1;
            if (done)                        loaded[ch_q] <= 1'b1;
        end
    end

    // One-hot word valid towards the latched channel.
    always_comb begin
        tgt_wr = '0;
        if (out_valid_q) tgt_wr[ch_q] = 1'b1;
    end
endmodule

// File: tb/tb_ioctl_word_loader.sv
// Bench for ioctl_word_loader: a 16-bit instance (default parameters) and a 32-bit
// instance with a 3-bit address (so address wrap is reachable) share one ioctl stream.
module tb_ioctl_word_loader;
    localparam int W16 = 2 + 13 + 16;
    localparam int W32 = 2 + 3 + 32;

    logic        clk, reset_n;
    logic        ioctl_download, ioctl_wr, tgt_req;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout, ioctl_index;

    logic        wait16, busy16, err16;
    logic [1:0]  tgt_wr16, loaded16;
    logic [12:0] tgt_addr16;
    logic [15:0] tgt_din16;

    logic        wait32, busy32, err32;
    logic [1:0]  tgt_wr32, loaded32;
    logic [2:0]  tgt_addr32;
    logic [31:0] tgt_din32;

    ioctl_word_loader dut16 (
        .clk_sys(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index), .ioctl_wait(wait16), .tgt_wr(tgt_wr16),
        .tgt_addr(tgt_addr16), .tgt_din(tgt_din16), .tgt_req(tgt_req),
        .loaded(loaded16), .busy(busy16), .err(err16)
    );

    ioctl_word_loader #(.OUT_W(32), .ADDR_W(3)) dut32 (
        .clk_sys(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index), .ioctl_wait(wait32), .tgt_wr(tgt_wr32),
        .tgt_addr(tgt_addr32), .tgt_din(tgt_din32), .tgt_req(tgt_req),
        .loaded(loaded32), .busy(busy32), .err(err32)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int              n_tests = 0;
    int              n_fail  = 0;
    logic [W16-1:0]  exp16_q[$];
    logic [W32-1:0]  exp32_q[$];
    logic [7:0]      file_q[$];
    logic [1:0]      loaded_m;
    logic            err32_m;
    int              req_mode;   // 0 never, 1 every 4th cycle, 2 random, 3 always

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: split the file into little-endian words, zero-padding the tail.
    task automatic add_expected(input int ch);
        int          n;
        int          nw16, nw32;
        logic [15:0] w16;
        logic [31:0] w32;
        n    = file_q.size();
        nw16 = (n + 1) / 2;
        nw32 = (n + 3) / 4;
        for (int k = 0; k < nw16; k++) begin
            w16 = '0;
            for (int j = 0; j < 2; j++)
                if (2 * k + j < n) w16[8 * j +: 8] = file_q[2 * k + j];
            exp16_q.push_back({2'(1 << ch), 13'(k), w16});
        end
        for (int k = 0; k < nw32; k++) begin
            w32 = '0;
            for (int j = 0; j < 4; j++)
                if (4 * k + j < n) w32[8 * j +: 8] = file_q[4 * k + j];
            exp32_q.push_back({2'(1 << ch), 3'(k), w32});
        end
        err32_m = (nw32 >= 8);
    endtask

    task automatic fill_random(input int n);
        file_q.delete();
        for (int i = 0; i < n; i++) file_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic fill_seq(input int n, input int first);
        file_q.delete();
        for (int i = 0; i < n; i++) file_q.push_back(8'(first + i));
    endtask

    // ---------------- tgt_req driver ----------------
    int cyc = 0;
    initial begin
        tgt_req = 1'b0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            case (req_mode)
                0:       tgt_req = 1'b0;
                1:       tgt_req = ((cyc % 4) == 0);
                2:       tgt_req = 1'($urandom_range(0, 1));
                default: tgt_req = 1'b1;
            endcase
        end
    end

    // ---------------- ioctl driver ----------------
    // Sends file_q as one download. Bytes go out only while the loaders are ready.
    // abort_after >= 0 returns early with download still high after that many bytes.
    task automatic run_download(input logic [7:0] idx, input int abort_after, input bit stall_watch);
        int i, stall;
        bit seen_wait, ok, in_range;
        i = 0; stall = 0; seen_wait = 0;
        in_range = (idx < 8'd2);
        if (in_range) begin
            loaded_m[idx[0]] = 1'b0;
            add_expected(int'(idx));
        end
        @(posedge clk); #1;
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        while (i < file_q.size() && i != abort_after) begin
            @(posedge clk); #1;
            ok = in_range ? (busy16 && busy32 && !wait16 && !wait32) : !(wait16 || wait32);
            if (stall_watch && wait16 && !seen_wait) begin
                seen_wait = 1'b1;
                check_val("wait_rise_byte", i, 2 * 63);
            end
            if (ok) begin
                ioctl_wr   = 1'b1;
                ioctl_addr = 25'(i);
                ioctl_dout = file_q[i];
                i++;
                stall = 0;
            end else begin
                ioctl_wr = 1'b0;
                stall++;
                if (stall_watch && stall == 20) req_mode = 2;
                if (stall > 3000) begin
                    check_val("byte_timeout", i, file_q.size());
                    break;
                end
            end
        end
        @(posedge clk); #1;
        ioctl_wr = 1'b0;
        if (stall_watch) check_val("wait_seen", seen_wait, 1);
        if (i == abort_after) return;
        @(posedge clk); #1;
        ioctl_download = 1'b0;
        if (in_range) loaded_m[idx[0]] = 1'b1;
    endtask

    task automatic wait_drain();
        int t;
        bit work;
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
            work = busy16 || busy32 || (exp16_q.size() != 0) || (exp32_q.size() != 0);
        end while (work && t < 5000);
        if (work) check_val("drain_timeout", {busy16, busy32, 16'(exp16_q.size()), 16'(exp32_q.size())}, 0);
        repeat (4) @(posedge clk);
        #1;
        check_val("loaded16", loaded16, loaded_m);
        check_val("loaded32", loaded32, loaded_m);
        check_val("err16", err16, 0);
        check_val("err32", err32, err32_m);
        check_val("wait_idle", {wait16, wait32}, 0);
    endtask

    // ---------------- monitors ----------------
    logic [W16-1:0] held16;
    logic [W32-1:0] held32;
    bit             stall16 = 0, stall32 = 0;
    logic [W16-1:0] e16;
    logic [W32-1:0] e32;

    always @(negedge clk) begin
        if (!reset_n) begin
            stall16 = 0;
            stall32 = 0;
        end else begin
            if (stall16) check_val("hold16", {tgt_wr16, tgt_addr16, tgt_din16}, held16);
            if (stall32) check_val("hold32", {tgt_wr32, tgt_addr32, tgt_din32}, held32);
            stall16 = (tgt_wr16 != 0) && !tgt_req;
            stall32 = (tgt_wr32 != 0) && !tgt_req;
            held16  = {tgt_wr16, tgt_addr16, tgt_din16};
            held32  = {tgt_wr32, tgt_addr32, tgt_din32};
            if (tgt_wr16 != 0 && tgt_req) begin
                if (exp16_q.size() == 0) check_val("extra16", {tgt_wr16, tgt_addr16, tgt_din16}, 0);
                else begin
                    e16 = exp16_q.pop_front();
                    check_val("word16", {tgt_wr16, tgt_addr16, tgt_din16}, e16);
                end
            end
            if (tgt_wr32 != 0 && tgt_req) begin
                if (exp32_q.size() == 0) check_val("extra32", {tgt_wr32, tgt_addr32, tgt_din32}, 0);
                else begin
                    e32 = exp32_q.pop_front();
                    check_val("word32", {tgt_wr32, tgt_addr32, tgt_din32}, e32);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        reset_n = 1'b0;
        ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0;
        req_mode = 0; loaded_m = '0; err32_m = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset16", {tgt_wr16, tgt_addr16, tgt_din16, loaded16, busy16, err16, wait16}, 0);
        check_val("reset32", {tgt_wr32, tgt_addr32, tgt_din32, loaded32, busy32, err32, wait32}, 0);
        reset_n = 1'b1;

        // 128 sequential bytes, slow target.
        req_mode = 1;
        fill_seq(128, 0);
        run_download(8'd0, -1, 1'b0);
        wait_drain();

        // 200 bytes with the target stalled until the loader pushes back.
        req_mode = 0;
        fill_random(200);
        run_download(8'd0, -1, 1'b1);
        wait_drain();

        // Out-of-range index: nothing may move.
        req_mode = 3;
        fill_random(20);
        run_download(8'd7, -1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check_val("oor_busy", {busy16, busy32}, 0);
        check_val("oor_loaded", loaded16, loaded_m);
        check_val("oor_err32", err32, err32_m);
        fill_random(30);
        run_download(8'd1, -1, 1'b0);
        wait_drain();

        // Short file with a partial final word.
        file_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_download(8'd0, -1, 1'b0);
        wait_drain();

        // 8 bytes 01..08.
        req_mode = 2;
        fill_seq(8, 1);
        run_download(8'd0, -1, 1'b0);
        wait_drain();

        // Reset in the middle of a load, then a full reload.
        req_mode = 3;
        fill_random(100);
        run_download(8'd1, 40, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check_val("midrst16", {tgt_wr16, tgt_addr16, tgt_din16, loaded16, busy16, err16, wait16}, 0);
        check_val("midrst32", {tgt_wr32, tgt_addr32, tgt_din32, loaded32, busy32, err32, wait32}, 0);
        ioctl_download = 1'b0;
        exp16_q.delete();
        exp32_q.delete();
        loaded_m = '0;
        err32_m  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        run_download(8'd1, -1, 1'b0);
        wait_drain();

        // New download starts while the previous one is still draining.
        req_mode = 1;
        fill_random(60);
        run_download(8'd0, -1, 1'b0);
        fill_random(40);
        run_download(8'd1, -1, 1'b0);
        wait_drain();

        // Random files, channels and target pacing.
        for (int r = 0; r < 6; r++) begin
            req_mode = $urandom_range(1, 3);
            fill_random($urandom_range(1, 150));
            run_download(8'($urandom_range(0, 1)), -1, 1'b0);
            wait_drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
